// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder with run-time fixed/round-robin selection.
// The output is carried on a valid/ready handshake with a multi-hot flag.
module prio_encoder_rr #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         req,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] out_code,
  output logic                 out_multi,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] ptr_q,      ptr_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic         out_multi_q, out_multi_d;
  logic         out_valid_q, out_valid_d;

  logic [W-1:0] grant_c;
  logic         multi_c;
  logic         cap_c;
  logic [W-1:0] idx;
  int unsigned  base;

  assign in_ready = !out_valid_q || out_ready;
  assign cap_c    = en && (|req) && in_ready;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_c  = |(req & (req - N'(1)));

  // Search order base-1, base-2, ... wrapping to base. Fixed priority is base=0,
  // which visits N-1 down to 0. Iterating from the far end lets the nearest win.
  always_comb begin
    grant_c = '0;
    idx     = '0;
    base    = mode ? 32'(ptr_q) : 32'd0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = W'((base + N - k) % N);
      if (req[idx]) grant_c = idx;
    end
  end

  // Next-state: capture wins over drain so back-to-back grants keep valid high.
  always_comb begin
    ptr_d       = ptr_q;
    out_code_d  = out_code_q;
    out_multi_d = out_multi_q;
    out_valid_d = out_valid_q;
    if (cap_c) begin
      out_code_d  = grant_c;
      out_multi_d = multi_c;
      out_valid_d = 1'b1;
      if (mode) ptr_d = grant_c;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_code_q  <= '0;
      out_multi_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_code_q  <= out_code_d;
      out_multi_q <= out_multi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_multi = out_multi_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=4 instance for the main sequence
// and an N=8 instance for the wider-code case.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, out_ready;
  logic [3:0] req;
  logic       in_ready;
  logic [1:0] out_code;
  logic       out_multi, out_valid;

  logic       en8, mode8, out_ready8;
  logic [7:0] req8;
  logic       in_ready8;
  logic [2:0] out_code8;
  logic       out_multi8, out_valid8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .in_ready(in_ready), .out_code(out_code), .out_multi(out_multi),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .req(req8),
    .in_ready(in_ready8), .out_code(out_code8), .out_multi(out_multi8),
    .out_valid(out_valid8), .out_ready(out_ready8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] code, input logic multi,
                         input logic valid);
    chk({tag, ".code"},  8'(out_code),  8'(code));
    chk({tag, ".multi"}, 8'(out_multi), 8'(multi));
    chk({tag, ".valid"}, 8'(out_valid), 8'(valid));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; out_ready = 1'b1; req = 4'b0000;
    en8 = 1'b1; mode8 = 1'b0; out_ready8 = 1'b1; req8 = 8'h00;
    step(); step();
    chk_out("reset", 2'd0, 1'b0, 1'b0);
    chk("reset.in_ready", 8'(in_ready), 8'd1);
    rst_n = 1'b1;

    // Fixed priority
    req = 4'b0100; step();
    chk_out("fp_0100", 2'd2, 1'b0, 1'b1);
    req = 4'b1011; step();
    chk_out("fp_1011", 2'd3, 1'b1, 1'b1);

    // Empty request drains the pending output, code holds
    req = 4'b0000; step();
    chk_out("empty", 2'd3, 1'b1, 1'b0);

    // Enable gating
    en = 1'b0; req = 4'b0001; step();
    chk_out("en_low", 2'd3, 1'b1, 1'b0);
    step();
    chk("en_low2.valid", 8'(out_valid), 8'd0);

    // Round-robin rotation, ptr starts at 0
    en = 1'b1; mode = 1'b1; req = 4'b1111;
    step(); chk_out("rr_a", 2'd3, 1'b1, 1'b1);
    step(); chk_out("rr_b", 2'd2, 1'b1, 1'b1);
    step(); chk_out("rr_c", 2'd1, 1'b1, 1'b1);
    step(); chk_out("rr_d", 2'd0, 1'b1, 1'b1);
    step(); chk_out("rr_e", 2'd3, 1'b1, 1'b1);

    // Round-robin skip
    req = 4'b1000; step(); chk_out("skip_a", 2'd3, 1'b0, 1'b1);
    req = 4'b1001; step(); chk_out("skip_b", 2'd0, 1'b1, 1'b1);
    step();                chk_out("skip_c", 2'd3, 1'b1, 1'b1);

    // Drain, then backpressure in fixed mode
    mode = 1'b0; req = 4'b0000; step();
    chk("drain.valid", 8'(out_valid), 8'd0);
    out_ready = 1'b0; req = 4'b0010; step();
    chk_out("bp_load", 2'd1, 1'b0, 1'b1);
    chk("bp_load.in_ready", 8'(in_ready), 8'd0);
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 2'd1, 1'b0, 1'b1);
      chk("bp_hold.in_ready", 8'(in_ready), 8'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp_release.in_ready", 8'(in_ready), 8'd1);
    step();
    chk_out("bp_release", 2'd3, 1'b0, 1'b1);

    // Wider instance
    req8 = 8'h80; step();
    chk("n8_80.code", 8'(out_code8), 8'd7);
    chk("n8_80.valid", 8'(out_valid8), 8'd1);
    req8 = 8'h05; step();
    chk("n8_05.code", 8'(out_code8), 8'd2);
    chk("n8_05.multi", 8'(out_multi8), 8'd1);
    req8 = 8'h00;

    // Put ptr at 2 (from ptr=3 with all requests) then reset asynchronously
    mode = 1'b1; req = 4'b1111; step();
    chk_out("pre_rst", 2'd2, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk_out("post_rst", 2'd3, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's 4:2 encoders.
- Converts an N-bit request vector into a binary index, using either fixed priority or round-robin arbitration, selected at run time.
- Output is registered and carried on a valid/ready handshake, with a multi-hot flag in place of the old don't-care output.
- Sits between request-generating blocks and any consumer of a granted channel index.

Parameters:
- N, 4, number of request inputs; legal values N >= 2.
- W, $clog2(N), output code width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when low, no capture occurs and state is held.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- req  input  N  request vector.
- in_ready  output  1  block can capture this cycle; combinational, equals !out_valid || out_ready.
- out_code  output  W  registered index of the granted request.
- out_multi  output  1  registered flag: more than one req bit was set at capture.
- out_valid  output  1  out_code and out_multi are valid.
- out_ready  input  1  consumer accepts the output.

Behaviour:
- Reset (rst_n low, asynchronous): out_code=0, out_multi=0, out_valid=0, ptr=0. Reset mid-transfer discards the pending output.
- Capture condition (cap): en && (|req) && in_ready, evaluated on each rising clk.
- Latency: one cycle from a req sample to out_valid.
- Fixed-priority search (mode 0):
  - Grant g is the highest set index of req.
  - For N=4 this matches the legacy encoding: req=4'b1000 gives 2'b11.
- Round-robin search (mode 1):
  - Search order is ptr-1, ptr-2, ..., wrapping modulo N, ending at ptr.
  - g is the first set bit found in that order.
  - Because ptr=0 after reset, the first round-robin grant equals the fixed-priority grant.
- Pointer state ptr[W-1:0]:
  - Updated only on cap with mode=1: ptr <= g.
  - Held on cap with mode=0.
  - Retained across mode changes.
- On cap: out_code <= g, out_multi <= (popcount(req) > 1), out_valid <= 1.
- No cap but out_valid && out_ready: out_valid <= 0; out_code and out_multi hold their last values.
- Simultaneous accept and capture (out_valid && out_ready && cap): new data is loaded and out_valid stays 1. This gives back-to-back throughput of one grant per cycle.
- Backpressure:
  - While out_valid && !out_ready, outputs and ptr are frozen and in_ready=0.
  - Requests asserted during this time are not stored; the requester must hold req.
- Empty request: req=0 never captures and never updates ptr, regardless of en.
- en low: no capture. A pending output can still drain via out_ready.
- No combinational path from req to out_code, out_multi or out_valid. in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset and fixed priority, N=4, mode=0, out_ready=1: after reset all outputs are 0. Drive req=4'b0100 for one cycle -> the next cycle shows out_code=2, out_valid=1, out_multi=0. Then drive req=4'b1011 -> out_code=3, out_multi=1.
- Round-robin rotation, N=4, mode=1, req held at 4'b1111, out_ready=1: successive grants are 3,2,1,0,3. out_valid stays 1 throughout and out_multi=1 on every grant.
- Round-robin skip, mode=1:
  - Grant 3 with req=4'b1000, leaving ptr=3.
  - Then req=4'b1001 -> grant 0, because search order is 2,1,0.
  - Then req=4'b1001 again -> grant 3.
- Backpressure, mode=0, out_ready=0:
  - req=4'b0010 -> out_code=1, out_valid=1.
  - Change req to 4'b1000 for 3 cycles: out_code stays 1 and in_ready=0.
  - Raise out_ready with req still 4'b1000 -> the next cycle shows out_code=3, out_valid=1.
- Empty and enable gating:
  - req=0, en=1 -> out_valid falls to 0 after accept.
  - req=4'b0001 with en=0 -> no capture.
  - Switch to N=8, mode=0, req=8'h80 -> out_code=3'd7.
- Asynchronous reset mid-operation: assert rst_n low between clock edges while out_valid=1 and ptr=2 -> out_valid=0 immediately, without waiting for clk. The first mode-1 grant with req=4'b1111 after release is 3.
